cache_control: RTL and testbench
================================

# cache_control

Sequencing FSM for the 2-way set-associative LC-3b cache datapath: 8 sets, 128-bit lines, 16-bit CPU words. It sits between the CPU memory port and physical memory. It turns hit, valid, dirty and LRU status from the datapath into array write enables, mux selects and the CPU and physical-memory handshakes. It handles read/write hits, clean misses and dirty write-back misses.

## Interface
Parameters: none.

Ports:
- clk  in  1  single clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high
- mem_read  in  1  CPU read request; held until mem_resp
- mem_write  in  1  CPU write request; held until mem_resp
- mem_byte_enable  in  2  CPU write byte mask
- tag_match0, tag_match1  in  1 each  stored tag of way N equals request tag
- valid0, valid1  in  1 each  valid bit of way N at current index
- dirty0, dirty1  in  1 each  dirty bit of way N at current index
- lru_out  in  1  least-recently-used way at current index
- pmem_resp  in  1  physical memory transfer complete (one-cycle pulse)
- mem_resp  out  1  CPU request complete
- pmem_read, pmem_write  out  1 each  physical memory requests
- pmem_addr_sel  out  1  0 = {request tag, index, 4'b0}; 1 = {victim stored tag, index, 4'b0}
- way_sel  out  1  datapath way-output mux select
- datain_sel  out  1  0 = pmem_rdata line; 1 = CPU-merged line
- membyte_sel  out  2  byte-merge select; equals mem_byte_enable
- data0_write, data1_write, tag0_write, tag1_write, valid0_write, valid1_write, dirty0_write, dirty1_write  out  1 each  array write enables
- dirty_in  out  1  value written to the dirty array
- lru_write, lru_in  out  1 each  LRU array write enable and data

## Operation
- Derived signals:
  - hit0 = valid0 & tag_match0
  - hit1 = valid1 & tag_match1
  - hit = hit0 | hit1
  - hit_way = ~hit0 & hit1 (way 0 wins if both hit)
- Request handling:
  - req = mem_read | mem_write.
  - If both are asserted, the request is treated as a write.
- Victim register victim_q (1 bit) latches lru_out on the miss-detect cycle.
- CHECK (reset state):
  - No req: all outputs 0 except membyte_sel.
  - Read hit:
    - mem_resp=1, way_sel=hit_way.
    - lru_write=1, lru_in=~hit_way.
    - Stay in CHECK.
  - Write hit:
    - mem_resp=1, way_sel=hit_way, datain_sel=1.
    - dataN_write=1 and dirtyN_write=1 for the hit way, dirty_in=1.
    - lru_write=1, lru_in=~hit_way.
    - If mem_byte_enable=2'b00, suppress the data and dirty writes; response and LRU update still occur.
  - Miss: load victim_q=lru_out. Next state is WRITEBACK if the victim way is both valid and dirty, otherwise ALLOCATE. No mem_resp.
- WRITEBACK:
  - pmem_write=1, pmem_addr_sel=1, way_sel=victim_q.
  - On pmem_resp, go to ALLOCATE.
- ALLOCATE:
  - pmem_read=1, pmem_addr_sel=0, datain_sel=0.
  - On pmem_resp, in the same cycle, assert the following for the victim way, then go to CHECK:
    - data write
    - tag write
    - valid write
    - dirty write with dirty_in=0
- After a fill, CHECK re-evaluates and the request completes as a hit. LRU changes only on hits.
- CPU drops req during a miss: the current pmem transfer completes, the FSM returns to CHECK, and no mem_resp is issued.
- Reset, at any time:
  - State goes to CHECK and victim_q to 0.
  - All outputs except membyte_sel are 0.
  - Any outstanding pmem transfer is abandoned.

## Timing
- mem_resp and array writes are Mealy outputs, combinational from the current state and inputs.
- Arrays read combinationally and write on the clock edge.
- Hit: mem_resp in the first cycle the request is seen in CHECK (0 wait states).
- Clean miss: 1 (CHECK) + Nr (ALLOCATE, ending with the pmem_resp cycle) + 1 (CHECK hit) cycles.
- Dirty miss: 1 + Nw + Nr + 1 cycles.
- pmem_read/pmem_write stay asserted, without change, until pmem_resp. They are never both high. They deassert the cycle after pmem_resp.
- mem_resp is high for exactly one cycle per completed request. The CPU must drop req or present a new one the next cycle.

## Test plan
- Reset, then a read at index 3, tag 0x12, with the set empty → ALLOCATE with pmem_read=1 and pmem_addr_sel=0. On pmem_resp: data0/tag0/valid0 write, dirty_in=0. The next cycle gives mem_resp=1 with lru_in=1.
- Write hit on way 1 with mem_byte_enable=2'b01 → same cycle: mem_resp=1, data1_write=1, dirty1_write=1, dirty_in=1, datain_sel=1, membyte_sel=2'b01, lru_in=0.
- Miss where the lru_out way is valid and dirty → WRITEBACK with pmem_write=1, pmem_addr_sel=1, way_sel=victim. Then ALLOCATE. Then a hit. Total latency is 2+Nw+Nr cycles with Nw=Nr=5.
- Write with mem_byte_enable=2'b00 on a hit → mem_resp=1, no data or dirty write, lru_write=1.
- Assert reset during ALLOCATE before pmem_resp → pmem_read drops immediately and the FSM is in CHECK with no mem_resp. After reset, the same read redoes the miss sequence.
- Dirty miss where req drops mid-WRITEBACK → write-back and allocate both complete, the FSM returns to CHECK, mem_resp is never asserted, and victim valid=1, dirty=0.

Source files
------------

// File: rtl/cache_control_if.sv
// Control/status bundle between the cache sequencer and the datapath/pmem side.
// The master modport is the controller; the slave modport is the datapath and memory environment.
interface cache_control_if;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_byte_enable;
    logic       mem_resp;

    logic       tag_match0;
    logic       tag_match1;
    logic       valid0;
    logic       valid1;
    logic       dirty0;
    logic       dirty1;
    logic       lru_out;

    logic       pmem_resp;
    logic       pmem_read;
    logic       pmem_write;
    logic       pmem_addr_sel;

    logic       way_sel;
    logic       datain_sel;
    logic [1:0] membyte_sel;
    logic       data0_write;
    logic       data1_write;
    logic       tag0_write;
    logic       tag1_write;
    logic       valid0_write;
    logic       valid1_write;
    logic       dirty0_write;
    logic       dirty1_write;
    logic       dirty_in;
    logic       lru_write;
    logic       lru_in;

    modport master (
        input  mem_read, mem_write, mem_byte_enable,
        input  tag_match0, tag_match1, valid0, valid1, dirty0, dirty1, lru_out,
        input  pmem_resp,
        output mem_resp, pmem_read, pmem_write, pmem_addr_sel,
        output way_sel, datain_sel, membyte_sel,
        output data0_write, data1_write, tag0_write, tag1_write,
        output valid0_write, valid1_write, dirty0_write, dirty1_write,
        output dirty_in, lru_write, lru_in
    );

    modport slave (
        output mem_read, mem_write, mem_byte_enable,
        output tag_match0, tag_match1, valid0, valid1, dirty0, dirty1, lru_out,
        output pmem_resp,
        input  mem_resp, pmem_read, pmem_write, pmem_addr_sel,
        input  way_sel, datain_sel, membyte_sel,
        input  data0_write, data1_write, tag0_write, tag1_write,
        input  valid0_write, valid1_write, dirty0_write, dirty1_write,
        input  dirty_in, lru_write, lru_in
    );
endinterface

// File: rtl/cache_control.sv
// Sequencing FSM for the 2-way set-associative LC-3b cache: hits complete in CHECK,
// misses optionally write back the LRU victim, then allocate and re-check as a hit.
module cache_control (
    input  logic                   clk,
    input  logic                   reset,
    cache_control_if.master        bus
);

    typedef enum logic [1:0] {
        S_CHECK     = 2'd0,
        S_WRITEBACK = 2'd1,
        S_ALLOCATE  = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   victim_q, victim_d;

    logic hit0, hit1, hit, hit_way, req, victim_dirty;

    assign hit0    = bus.valid0 & bus.tag_match0;
    assign hit1    = bus.valid1 & bus.tag_match1;
    assign hit     = hit0 | hit1;
    assign hit_way = ~hit0 & hit1;
    assign req     = bus.mem_read | bus.mem_write;

    // Only a victim that is both valid and dirty needs to reach memory before refill.
    assign victim_dirty = bus.lru_out ? (bus.valid1 & bus.dirty1)
                                      : (bus.valid0 & bus.dirty0);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_CHECK;
            victim_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
        end
    end

    // NOTE: every output and next-state variable gets a default before the case,
    // so no path through this block can leave one unassigned and infer a latch.
    always_comb begin
        state_d           = state_q;
        victim_d          = victim_q;
        bus.mem_resp      = 1'b0;
        bus.pmem_read     = 1'b0;
        bus.pmem_write    = 1'b0;
        bus.pmem_addr_sel = 1'b0;
        bus.way_sel       = 1'b0;
        bus.datain_sel    = 1'b0;
        bus.membyte_sel   = bus.mem_byte_enable;
        bus.data0_write   = 1'b0;
        bus.data1_write   = 1'b0;
        bus.tag0_write    = 1'b0;
        bus.tag1_write    = 1'b0;
        bus.valid0_write  = 1'b0;
        bus.valid1_write  = 1'b0;
        bus.dirty0_write  = 1'b0;
        bus.dirty1_write  = 1'b0;
        bus.dirty_in      = 1'b0;
        bus.lru_write     = 1'b0;
        bus.lru_in        = 1'b0;

        // Outputs are silenced while reset is held so no array write or pmem
        // request can leak out of an abandoned transfer.
        if (!reset) begin
            case (state_q)
                S_CHECK: begin
                    if (req) begin
                        if (hit) begin
                            bus.mem_resp  = 1'b1;
                            bus.way_sel   = hit_way;
                            bus.lru_write = 1'b1;
                            bus.lru_in    = ~hit_way;
                            if (bus.mem_write) begin
                                bus.datain_sel = 1'b1;
                                bus.dirty_in   = 1'b1;
                                if (|bus.mem_byte_enable) begin
                                    bus.data0_write  = ~hit_way;
                                    bus.dirty0_write = ~hit_way;
                                    bus.data1_write  = hit_way;
                                    bus.dirty1_write = hit_way;
                                end
                            end
                        end else begin
                            victim_d = bus.lru_out;
                            state_d  = victim_dirty ? S_WRITEBACK : S_ALLOCATE;
                        end
                    end
                end

                S_WRITEBACK: begin
                    bus.pmem_write    = 1'b1;
                    bus.pmem_addr_sel = 1'b1;
                    bus.way_sel       = victim_q;
                    if (bus.pmem_resp) begin
                        state_d = S_ALLOCATE;
                    end
                end

                S_ALLOCATE: begin
                    bus.pmem_read = 1'b1;
                    if (bus.pmem_resp) begin
                        bus.data0_write  = ~victim_q;
                        bus.tag0_write   = ~victim_q;
                        bus.valid0_write = ~victim_q;
                        bus.dirty0_write = ~victim_q;
                        bus.data1_write  = victim_q;
                        bus.tag1_write   = victim_q;
                        bus.valid1_write = victim_q;
                        bus.dirty1_write = victim_q;
                        state_d          = S_CHECK;
                    end
                end

                default: state_d = S_CHECK;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_control.sv
// Directed bench for cache_control: a behavioural tag/valid/dirty/LRU array and a
// fixed-latency pmem responder around the FSM, with a latency scoreboard for CPU requests.
module tb_cache_control;

    localparam int N_MEM = 5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cache_control_if bus ();

    cache_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Datapath status model, indexed by the current request address.
    logic [2:0] idx;
    logic [8:0] req_tag;
    logic [8:0] tag_a   [8][2] = '{default: '0};
    logic       valid_a [8][2] = '{default: '0};
    logic       dirty_a [8][2] = '{default: '0};
    logic       lru_a   [8]    = '{default: '0};

    assign bus.tag_match0 = (tag_a[idx][0] == req_tag);
    assign bus.tag_match1 = (tag_a[idx][1] == req_tag);
    assign bus.valid0     = valid_a[idx][0];
    assign bus.valid1     = valid_a[idx][1];
    assign bus.dirty0     = dirty_a[idx][0];
    assign bus.dirty1     = dirty_a[idx][1];
    assign bus.lru_out    = lru_a[idx];

    always @(posedge clk) begin
        if (bus.tag0_write)   tag_a[idx][0]   <= req_tag;
        if (bus.tag1_write)   tag_a[idx][1]   <= req_tag;
        if (bus.valid0_write) valid_a[idx][0] <= 1'b1;
        if (bus.valid1_write) valid_a[idx][1] <= 1'b1;
        if (bus.dirty0_write) dirty_a[idx][0] <= bus.dirty_in;
        if (bus.dirty1_write) dirty_a[idx][1] <= bus.dirty_in;
        if (bus.lru_write)    lru_a[idx]      <= bus.lru_in;
    end

    // pmem answers with a one-cycle pulse in the N_MEM-th cycle of a request.
    logic [3:0] pm_cnt;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            pm_cnt        <= '0;
            bus.pmem_resp <= 1'b0;
        end else if (bus.pmem_resp) begin
            pm_cnt        <= '0;
            bus.pmem_resp <= 1'b0;
        end else if (bus.pmem_read || bus.pmem_write) begin
            pm_cnt        <= pm_cnt + 4'd1;
            bus.pmem_resp <= (pm_cnt == 4'(N_MEM - 2));
        end else begin
            pm_cnt <= '0;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int resp_cnt = 0;
    always @(negedge clk) if (bus.mem_resp) resp_cnt <= resp_cnt + 1;

    typedef struct {
        string name;
        int    lat;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   start_cyc;
    int   n_issued = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [1:0] be, input logic [8:0] tag,
                         input logic [2:0] index, input int lat, input string name);
        exp_t e;
        bus.mem_read        = ~wr;
        bus.mem_write       = wr;
        bus.mem_byte_enable = be;
        req_tag             = tag;
        idx                 = index;
        start_cyc           = cyc;
        e.name              = name;
        e.lat               = lat;
        exp_q.push_back(e);
        n_issued++;
    endtask

    // Called at a sample point; waits (bounded) for mem_resp and scores its latency.
    task automatic wait_resp(input int budget);
        exp_t e;
        int   n = 0;
        while (!bus.mem_resp && n < budget) begin
            step();
            #1;
            n++;
        end
        if (exp_q.size() == 0) begin
            check("scoreboard underflow", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check({e.name, " latency"}, bus.mem_resp ? 32'(cyc - start_cyc + 1) : 32'd0,
                  32'(e.lat));
        end
    endtask

    task automatic wait_pmem_resp(input int budget, input string name);
        int n = 0;
        while (!bus.pmem_resp && n < budget) begin
            step();
            #1;
            n++;
        end
        check(name, bus.pmem_resp, 1'b1);
    endtask

    task automatic finish_req();
        step();
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
    endtask

    int r0;

    initial begin
        reset               = 1'b1;
        bus.mem_read        = 1'b1;
        bus.mem_write       = 1'b0;
        bus.mem_byte_enable = 2'b10;
        idx                 = 3'd3;
        req_tag             = 9'h012;
        step();
        step();
        #1;
        check("reset mem_resp",    bus.mem_resp,    1'b0);
        check("reset pmem_read",   bus.pmem_read,   1'b0);
        check("reset lru_write",   bus.lru_write,   1'b0);
        check("reset membyte_sel", bus.membyte_sel, 2'b10);
        step();
        bus.mem_read = 1'b0;
        reset        = 1'b0;
        step();

        // Clean read miss into empty set 3: fills way 0, then hits.
        issue(1'b0, 2'b00, 9'h012, 3'd3, 7, "clean miss");
        #1;
        check("miss cycle mem_resp",  bus.mem_resp,  1'b0);
        check("miss cycle pmem_read", bus.pmem_read, 1'b0);
        step();
        #1;
        check("alloc pmem_read",     bus.pmem_read,     1'b1);
        check("alloc pmem_write",    bus.pmem_write,    1'b0);
        check("alloc pmem_addr_sel", bus.pmem_addr_sel, 1'b0);
        check("alloc datain_sel",    bus.datain_sel,    1'b0);
        wait_pmem_resp(20, "alloc pmem_resp");
        check("fill data0_write",  bus.data0_write,  1'b1);
        check("fill tag0_write",   bus.tag0_write,   1'b1);
        check("fill valid0_write", bus.valid0_write, 1'b1);
        check("fill dirty0_write", bus.dirty0_write, 1'b1);
        check("fill dirty_in",     bus.dirty_in,     1'b0);
        check("fill data1_write",  bus.data1_write,  1'b0);
        check("fill lru_write",    bus.lru_write,    1'b0);
        step();
        #1;
        check("post fill pmem_read", bus.pmem_read, 1'b0);
        wait_resp(20);
        check("clean miss lru_write", bus.lru_write, 1'b1);
        check("clean miss lru_in",    bus.lru_in,    1'b1);
        check("clean miss way_sel",   bus.way_sel,   1'b0);
        finish_req();

        // Second clean miss in set 3 lands in way 1 (LRU now points there).
        issue(1'b0, 2'b00, 9'h034, 3'd3, 7, "way1 fill");
        #1;
        wait_resp(20);
        check("way1 fill lru_in", bus.lru_in, 1'b0);
        finish_req();

        // Write hit on way 1, low byte only.
        issue(1'b1, 2'b01, 9'h034, 3'd3, 1, "write hit w1");
        #1;
        wait_resp(20);
        check("whit data1_write",  bus.data1_write,  1'b1);
        check("whit dirty1_write", bus.dirty1_write, 1'b1);
        check("whit data0_write",  bus.data0_write,  1'b0);
        check("whit dirty_in",     bus.dirty_in,     1'b1);
        check("whit datain_sel",   bus.datain_sel,   1'b1);
        check("whit membyte_sel",  bus.membyte_sel,  2'b01);
        check("whit way_sel",      bus.way_sel,      1'b1);
        check("whit lru_in",       bus.lru_in,       1'b0);
        finish_req();

        // Write hit on way 0 with no bytes enabled: response and LRU only.
        issue(1'b1, 2'b00, 9'h012, 3'd3, 1, "be00 hit");
        #1;
        wait_resp(20);
        check("be00 data0_write",  bus.data0_write,  1'b0);
        check("be00 dirty0_write", bus.dirty0_write, 1'b0);
        check("be00 lru_write",    bus.lru_write,    1'b1);
        check("be00 lru_in",       bus.lru_in,       1'b1);
        finish_req();

        // Dirty miss: LRU is way 1, which is valid and dirty.
        issue(1'b0, 2'b00, 9'h056, 3'd3, 12, "dirty miss");
        #1;
        check("dmiss cycle mem_resp", bus.mem_resp, 1'b0);
        step();
        #1;
        check("wb pmem_write",    bus.pmem_write,    1'b1);
        check("wb pmem_read",     bus.pmem_read,     1'b0);
        check("wb pmem_addr_sel", bus.pmem_addr_sel, 1'b1);
        check("wb way_sel",       bus.way_sel,       1'b1);
        wait_pmem_resp(20, "wb pmem_resp");
        step();
        #1;
        check("after wb pmem_write", bus.pmem_write, 1'b0);
        check("after wb pmem_read",  bus.pmem_read,  1'b1);
        wait_resp(30);
        finish_req();
        check("dmiss way1 tag",   tag_a[3][1],   9'h056);
        check("dmiss way1 dirty", dirty_a[3][1], 1'b0);

        // Reset in the middle of ALLOCATE abandons the transfer; the read then retries.
        bus.mem_read  = 1'b1;
        bus.mem_write = 1'b0;
        idx           = 3'd5;
        req_tag       = 9'h007;
        step();
        #1;
        check("pre-reset pmem_read", bus.pmem_read, 1'b1);
        r0 = resp_cnt;
        step();
        reset = 1'b1;
        #1;
        check("reset drop pmem_read", bus.pmem_read, 1'b0);
        check("reset drop mem_resp",  bus.mem_resp,  1'b0);
        step();
        reset = 1'b0;
        start_cyc = cyc;
        exp_q.push_back('{name: "redo miss", lat: 7});
        n_issued++;
        #1;
        check("redo check pmem_read", bus.pmem_read,   1'b0);
        check("redo set still empty", valid_a[5][0],   1'b0);
        check("no resp during reset", 32'(resp_cnt), 32'(r0));
        wait_resp(20);
        finish_req();

        // Set 6: make way 0 dirty and LRU, way 1 clean.
        issue(1'b0, 2'b00, 9'h001, 3'd6, 7, "s6 fill0");
        #1;
        wait_resp(20);
        finish_req();
        issue(1'b1, 2'b11, 9'h001, 3'd6, 1, "s6 dirty0");
        #1;
        wait_resp(20);
        finish_req();
        issue(1'b0, 2'b00, 9'h002, 3'd6, 7, "s6 fill1");
        #1;
        wait_resp(20);
        finish_req();

        // Dirty miss with the CPU giving up mid-writeback.
        bus.mem_read = 1'b1;
        req_tag      = 9'h003;
        r0           = resp_cnt;
        step();
        #1;
        check("drop wb pmem_write", bus.pmem_write, 1'b1);
        step();
        bus.mem_read = 1'b0;
        #1;
        check("wb held after drop", bus.pmem_write, 1'b1);
        wait_pmem_resp(20, "drop wb pmem_resp");
        step();
        #1;
        check("drop alloc pmem_read", bus.pmem_read, 1'b1);
        wait_pmem_resp(20, "drop alloc pmem_resp");
        check("drop fill valid0_write", bus.valid0_write, 1'b1);
        check("drop fill dirty_in",     bus.dirty_in,     1'b0);
        step();
        #1;
        check("drop idle pmem_read",  bus.pmem_read,  1'b0);
        check("drop idle pmem_write", bus.pmem_write, 1'b0);
        check("drop idle mem_resp",   bus.mem_resp,   1'b0);
        step();
        step();
        check("drop no mem_resp",   32'(resp_cnt), 32'(r0));
        check("drop victim valid",  valid_a[6][0], 1'b1);
        check("drop victim dirty",  dirty_a[6][0], 1'b0);
        check("drop victim tag",    tag_a[6][0],   9'h003);

        check("mem_resp pulse count", 32'(resp_cnt), 32'(n_issued));
        check("scoreboard drained",   32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
